mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory among N requesters.
// Tracks granted requests through a fixed-latency tag pipe for response routing.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_PORTS   = 2,
  parameter int MEM_LAT   = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  output logic [N_PORTS-1:0]        req_ready,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS-1:0]        req_we,
  input  logic [N_PORTS*DATA_W-1:0] req_wdata,
  input  logic [N_PORTS*2-1:0]      req_size,
  input  logic [N_PORTS-1:0]        req_sign,
  input  logic [N_PORTS-1:0]        flush,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [1:0]                mem_size,
  output logic                      mem_sign,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PW = $clog2(N_PORTS);

  typedef logic [PW-1:0] pid_t;

  typedef struct packed {
    logic vld;
    pid_t port;
    logic we;
  } tag_t;

  pid_t        ptr_q;
  pid_t        ptr_d;
  pid_t        base;
  pid_t        gnt_idx;
  logic        gnt_any;
  logic        xfer;
  logic [PW:0] cand;
  tag_t        stg_q [MEM_LAT];
  tag_t        stg_d [MEM_LAT];
  tag_t        last;
  logic        rsp_hit;

  // Search starts at the pointer in round-robin mode, at port 0 otherwise.
  always_comb begin
    base    = (PRIO_MODE != 0) ? ptr_q : '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 0; off < N_PORTS; off++) begin
      cand = {1'b0, base} + (PW+1)'(off);
      if (cand >= (PW+1)'(N_PORTS))
        cand = cand - (PW+1)'(N_PORTS);
      if (!gnt_any && req_valid[cand[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  assign xfer      = gnt_any & ~rst;
  assign req_ready = xfer ? (N_PORTS'(1) << gnt_idx) : '0;

  assign mem_en    = gnt_any;
  assign mem_we    = gnt_any ? req_we[gnt_idx] : 1'b0;
  assign mem_sign  = gnt_any ? req_sign[gnt_idx] : 1'b0;
  assign mem_addr  = gnt_any ? req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
  assign mem_wdata = gnt_any ? req_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
  assign mem_size  = gnt_any ? req_size[int'(gnt_idx)*2 +: 2] : 2'b00;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && PRIO_MODE != 0)
      ptr_d = (gnt_idx == pid_t'(N_PORTS-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Flush kills matching tags both entering and moving down the pipe.
  always_comb begin
    stg_d[0].vld  = xfer & ~flush[gnt_idx];
    stg_d[0].port = gnt_idx;
    stg_d[0].we   = mem_we;
    for (int j = 1; j < MEM_LAT; j++) begin
      stg_d[j]     = stg_q[j-1];
      stg_d[j].vld = stg_q[j-1].vld & ~flush[stg_q[j-1].port];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int j = 0; j < MEM_LAT; j++)
        stg_q[j] <= '0;
    end else begin
      ptr_q <= ptr_d;
      stg_q <= stg_d;
    end
  end

  assign last    = stg_q[MEM_LAT-1];
  assign rsp_hit = last.vld & ~flush[last.port] & ~rst;

  assign rsp_valid = rsp_hit ? (N_PORTS'(1) << last.port) : '0;
  assign rsp_rdata = (rsp_hit && !last.we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic into fixed (lat 1) and round-robin (lat 3) arbiters.
// A queue-based reference model predicts grants and responses.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    req_sign = '0;
  logic [N-1:0]    flush = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [2*N-1:0]  req_size = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  typedef struct {
    logic [N-1:0]  rdy;
    bit            chk;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wd;
    logic [1:0]    sz;
    logic          sg;
  } g_t;

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } r_t;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [N-1:0]  rdy;
    logic [N-1:0]  rsp_v;
    logic [DW-1:0] rsp_d;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_size;
    logic          m_sign;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] ap [LAT];

    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .N_PORTS(N),
      .MEM_LAT(LAT), .PRIO_MODE(g)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(rdy),
      .req_addr(req_addr), .req_we(req_we),
      .req_wdata(req_wdata), .req_size(req_size),
      .req_sign(req_sign), .flush(flush),
      .rsp_valid(rsp_v), .rsp_rdata(rsp_d),
      .mem_en(m_en), .mem_we(m_we),
      .mem_addr(m_addr), .mem_wdata(m_wdata),
      .mem_size(m_size), .mem_sign(m_sign),
      .mem_rdata(m_rdata)
    );

    // Memory stand-in: data is a hash of the address issued LAT cycles ago.
    always @(posedge clk) begin
      ap[0] <= m_addr;
      for (int j = 1; j < LAT; j++) ap[j] <= ap[j-1];
    end
    assign m_rdata = hsh(ap[LAT-1]);

    g_t gq[$];
    r_t rq[$];
    int ptr = 0;
    int mk;
    int bs;
    g_t me;
    r_t mr;
    g_t ce;
    r_t cr;
    logic [N-1:0] ev;

    always @(posedge clk) begin
      #2;
      if (rst) begin
        rq.delete();
        ptr = 0;
        if (|req_valid) begin
          me = '{default: 0};
          gq.push_back(me);
        end
      end else begin
        for (int i = rq.size() - 1; i >= 0; i--)
          if (flush[rq[i].port]) rq.delete(i);
        bs = (g == 1) ? ptr : 0;
        mk = -1;
        for (int off = 0; off < N; off++)
          if (mk < 0 && req_valid[(bs + off) % N]) mk = (bs + off) % N;
        if (mk >= 0) begin
          me.rdy     = '0;
          me.rdy[mk] = 1'b1;
          me.chk     = 1;
          me.addr    = req_addr[mk*AW +: AW];
          me.we      = req_we[mk];
          me.wd      = req_wdata[mk*DW +: DW];
          me.sz      = req_size[mk*2 +: 2];
          me.sg      = req_sign[mk];
          gq.push_back(me);
          if (!flush[mk]) begin
            mr.due  = cyc + LAT;
            mr.port = mk;
            mr.data = req_we[mk] ? '0 : hsh(me.addr);
            rq.push_back(mr);
          end
          if (g == 1) ptr = (mk + 1) % N;
        end
      end
    end

    always @(negedge clk) begin
      if (cyc >= 1) begin
        if (rdy != '0 || m_en) begin
          total++;
          if (gq.size() == 0) begin
            bad++;
            $display("FAIL u%0d grant_extra cyc=%0d got rdy=%b en=%b want none",
                     g, cyc, rdy, m_en);
          end else begin
            ce = gq.pop_front();
            if (rdy !== ce.rdy || !m_en ||
                (ce.chk && {m_addr, m_we, m_wdata, m_size, m_sign} !==
                           {ce.addr, ce.we, ce.wd, ce.sz, ce.sg})) begin
              bad++;
              $display("FAIL u%0d grant cyc=%0d got rdy=%b a=%h we=%b wd=%h sz=%b sg=%b want rdy=%b a=%h we=%b wd=%h sz=%b sg=%b",
                       g, cyc, rdy, m_addr, m_we, m_wdata, m_size, m_sign,
                       ce.rdy, ce.addr, ce.we, ce.wd, ce.sz, ce.sg);
            end
          end
        end else begin
          total++;
          if ({m_addr, m_we, m_wdata, m_size, m_sign} !== '0) begin
            bad++;
            $display("FAIL u%0d idle_fields cyc=%0d got a=%h wd=%h want 0",
                     g, cyc, m_addr, m_wdata);
          end
        end
        if (gq.size() != 0) begin
          total++;
          bad++;
          $display("FAIL u%0d grant_missing cyc=%0d got rdy=%b en=%b want rdy=%b",
                   g, cyc, rdy, m_en, gq[0].rdy);
          gq.delete();
        end
        if (rq.size() != 0 && rq[0].due <= cyc) begin
          cr = rq.pop_front();
          ev = '0;
          ev[cr.port] = 1'b1;
          total++;
          if (rsp_v !== ev || rsp_d !== cr.data) begin
            bad++;
            $display("FAIL u%0d rsp cyc=%0d got v=%b d=%h want v=%b d=%h",
                     g, cyc, rsp_v, rsp_d, ev, cr.data);
          end
        end else begin
          total++;
          if (rsp_v !== '0 || rsp_d !== '0) begin
            bad++;
            $display("FAIL u%0d rsp_extra cyc=%0d got v=%b d=%h want v=0 d=0",
                     g, cyc, rsp_v, rsp_d);
          end
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] fl,
                      input logic r, input logic [N-1:0] wem);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    flush     = fl;
    req_we    = wem;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = $urandom;
      req_wdata[i*DW +: DW] = $urandom;
      req_size[i*2 +: 2]    = 2'($urandom_range(0, 2));
      req_sign[i]           = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0, '0);
  endtask

  initial begin
    repeat (2) step('0, '0, 1'b1, '0);
    step(3'b010, '0, 1'b0, '0);
    idle(4);
    repeat (3) step(3'b011, '0, 1'b0, '0);
    step(3'b010, '0, 1'b0, '0);
    idle(4);
    repeat (6) step(3'b111, '0, 1'b0, '0);
    idle(4);
    step(3'b010, '0, 1'b0, '0);
    step(3'b010, '0, 1'b0, '0);
    step(3'b001, 3'b010, 1'b0, '0);
    idle(5);
    step(3'b001, '0, 1'b0, 3'b001);
    idle(4);
    step(3'b001, '0, 1'b0, '0);
    step(3'b011, '0, 1'b1, '0);
    idle(4);
    repeat (3000)
      step(N'($urandom),
           ($urandom_range(0, 7) == 0) ? N'($urandom) : '0,
           ($urandom_range(0, 199) == 0),
           N'($urandom));
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
